cheri_trvk_mc: RTL and testbench
================================

# cheri_trvk_mc

Multi-channel, parametrised temporal-safety revocation lookup stage for the CHERIoT pipeline. It accepts loaded capabilities from up to NumCh requesters (CPU load-cap path, TBRE, further DMA/background engines) through valid/ready handshakes and arbitrates them round-robin onto one shared revocation-bitmap (tsmap) read port. For each request it returns a fixed-latency verdict telling the requester whether to clear the capability tag. Granule size, bitmap word width, map depth and channel count are all parameters.

## Interface
- HeapBase, 32'h8000_0000, first byte address covered by the map
- TSMapSize, 1024, number of valid map words; word index must be < TSMapSize
- NumCh, 2, requester channels (1..8)
- GranLog2, 3, log2 of revocation granule in bytes
- TSMapDW, 32, map word width (power of 2, 8..64)
- TSMapAW, 16, map word address width
- TagW, 5, per-request opaque tag width (e.g. RF write address)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- revoke_en_i  in  1  global enable; 0 forces every verdict to "keep"
- req_valid_i  in  NumCh  request valid per channel
- req_ready_o  out  NumCh  request accepted this cycle (one-hot or zero)
- req_cap_i  in  NumCh x reg_cap_t  loaded capability
- req_data_i  in  NumCh x 32  loaded address word
- req_err_i  in  NumCh  load error; request still consumes a slot
- req_tag_i  in  NumCh x TagW  opaque tag, returned unchanged
- rsp_valid_o  out  NumCh  verdict valid, one-hot or zero
- rsp_clrtag_o  out  1  1 = clear tag of returned capability
- rsp_tag_o  out  TagW  tag of the answered request
- tsmap_cs_o  out  1  map read strobe
- tsmap_addr_o  out  TSMapAW  map word address
- tsmap_rdata_i  in  TSMapDW  map word, valid exactly one cycle after tsmap_cs_o

## Operation
- Arbitration: each cycle the round-robin arbiter grants the lowest-index requesting channel at or after rr_ptr; req_ready_o = grant. rr_ptr advances to granted+1 (mod NumCh) only on a grant. No output back-pressure; a channel may be granted every cycle if it is the only requester.
- Requester holds valid, cap, data, tag stable until ready; de-asserting valid without ready is legal (request withdrawn).
- S0 (grant cycle edge): register cap, data, tag, channel one-hot, err; s0_valid set.
- S1: base32 = low 32 bits of get_bound33(base, base_cor, exp, data); off = base32 - HeapBase (mod 2^32); gidx = off >> GranLog2; widx = gidx >> log2(TSMapDW); bit = gidx[log2(TSMapDW)-1:0]. check = s0_valid & ~err & cap.valid & ~sealed & (widx < TSMapSize) & revoke_en_i. sealed = (cperms[4:3]==2'b00) & |cperms[2:0]. tsmap_cs_o = check; tsmap_addr_o = widx[TSMapAW-1:0]. Register check, bit, tag, channel.
- S2: clrtag = check_q & tsmap_rdata_i[bit_q]; register into output stage.
- Base below HeapBase wraps to a large widx, fails range, verdict keep. Errored, untagged, sealed or out-of-range requests still produce a response with rsp_clrtag_o = 0 and no map read.
- revoke_en_i is sampled in S1 only.

## Timing
- Grant in cycle T -> tsmap_cs_o in T+1 -> rdata in T+2 -> rsp_valid_o[ch] high for exactly one cycle in T+3.
- Throughput one request per cycle; responses in grant order.
- rsp_clrtag_o and rsp_tag_o are 0 whenever rsp_valid_o == 0.
- Reset (any cycle, including mid-pipeline): all stage valids, rsp_valid_o, rsp_clrtag_o, rsp_tag_o, tsmap_cs_o, tsmap_addr_o, req_ready_o = 0; rr_ptr = 0; in-flight requests dropped, no response issued.
- req_ready_o is combinational from req_valid_i and rr_ptr; no combinational path from tsmap_rdata_i to any output.

## Structure
- cheri_pkg supplies reg_cap_t, NULL_REG_CAP, get_bound33; add typedef trvk_req_t (cap, data, err, tag) and function cap_is_sealed().
- Sub-module cheri_trvk_rrarb: parametrised NumCh round-robin arbiter with rr_ptr state.
- Parameter legality checks as elaboration-time assertions.

## Test plan
- Single hit: ch0, base 0x8000_0108, tag 5'h07, map word 1 = 0x0000_0002 -> tsmap_addr_o=1 at T+1, rsp_valid_o=01, rsp_clrtag_o=1, tag 7 at T+3.
- Miss and guards: same cap with rdata 0 -> clrtag 0; sealed (cperms=3'b001) or req_err_i=1 -> no tsmap_cs_o, clrtag 0.
- Range: base 0x7FFF_FFF8 and base giving widx=TSMapSize -> no map read, clrtag 0; widx=TSMapSize-1 -> read issued.
- Arbitration: both channels valid 4 cycles -> grants alternate 01,10,01,10; responses follow same order, 1 per cycle.
- Back-to-back: 3 consecutive ch1 requests with differing bits -> 3 consecutive correct verdicts, no bubbles.
- Reset at T+2 of an in-flight request -> no rsp_valid_o afterwards; first grant post-reset goes to ch0.

Source files
------------

// File: rtl/cheri_trvk_mc_pkg.sv
// Capability register types and bound helpers shared by the revocation lookup stage.
package cheri_trvk_mc_pkg;

    localparam int unsigned TrvkTagMaxW = 8;

    typedef struct packed {
        logic       valid;
        logic [1:0] top_cor;
        logic [1:0] base_cor;
        logic [4:0] exp;
        logic [8:0] top;
        logic [8:0] base;
        logic [5:0] cperms;
    } reg_cap_t;

    localparam reg_cap_t NULL_REG_CAP = '0;

    typedef struct packed {
        reg_cap_t               cap;
        logic [31:0]            data;
        logic                   err;
        logic [TrvkTagMaxW-1:0] tag;
    } trvk_req_t;

    localparam trvk_req_t NULL_TRVK_REQ = '{cap: NULL_REG_CAP, data: '0, err: 1'b0, tag: '0};

    // Rebuild a full bound from its 9-bit mantissa, the address and the 2-bit correction (01 = +1, 11 = -1).
    function automatic logic [32:0] get_bound33(input logic [8:0] bound, input logic [1:0] cor,
                                                input logic [4:0] exp, input logic [31:0] addr);
        logic [5:0]  sh;
        logic [32:0] mask;
        logic [32:0] cor_val;
        sh   = 6'(exp) + 6'd9;
        mask = {33{1'b1}} << sh;
        case (cor)
            2'b01:   cor_val = 33'd1;
            2'b11:   cor_val = {33{1'b1}};
            default: cor_val = 33'd0;
        endcase
        cor_val = cor_val << sh;
        return (({1'b0, addr} & mask) + cor_val) | ({24'd0, bound} << exp);
    endfunction

    function automatic logic cap_is_sealed(input reg_cap_t cap);
        return (cap.cperms[4:3] == 2'b00) && (|cap.cperms[2:0]);
    endfunction

endpackage

// File: rtl/cheri_trvk_mc_if.sv
// Requester, response and revocation-map port bundle of the lookup stage.
interface cheri_trvk_mc_if
    import cheri_trvk_mc_pkg::*;
#(
    parameter int unsigned NumCh   = 2,
    parameter int unsigned TagW    = 5,
    parameter int unsigned TSMapDW = 32,
    parameter int unsigned TSMapAW = 16
);
    logic                           revoke_en;
    logic [NumCh-1:0]               req_valid;
    logic [NumCh-1:0]               req_ready;
    reg_cap_t [NumCh-1:0]           req_cap;
    logic [NumCh-1:0][31:0]         req_data;
    logic [NumCh-1:0]               req_err;
    logic [NumCh-1:0][TagW-1:0]     req_tag;
    logic [NumCh-1:0]               rsp_valid;
    logic                           rsp_clrtag;
    logic [TagW-1:0]                rsp_tag;
    logic                           tsmap_cs;
    logic [TSMapAW-1:0]             tsmap_addr;
    logic [TSMapDW-1:0]             tsmap_rdata;

    modport master (
        output revoke_en, req_valid, req_cap, req_data, req_err, req_tag, tsmap_rdata,
        input  req_ready, rsp_valid, rsp_clrtag, rsp_tag, tsmap_cs, tsmap_addr
    );

    modport slave (
        input  revoke_en, req_valid, req_cap, req_data, req_err, req_tag, tsmap_rdata,
        output req_ready, rsp_valid, rsp_clrtag, rsp_tag, tsmap_cs, tsmap_addr
    );
endinterface

// File: rtl/cheri_trvk_rrarb.sv
// Round-robin arbiter: grants the first requester at or after the pointer, pointer moves past the winner.
module cheri_trvk_rrarb #(
    parameter int unsigned NumCh = 2,
    parameter int unsigned IdxW  = (NumCh > 1) ? $clog2(NumCh) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [NumCh-1:0] i_req,
    output logic [NumCh-1:0] o_gnt,
    output logic [IdxW-1:0]  o_gnt_idx
);
    logic [IdxW-1:0] r_ptr;

    always_comb begin
        logic        w_found;
        int unsigned w_cand;
        o_gnt     = '0;
        o_gnt_idx = '0;
        w_found   = 1'b0;
        w_cand    = 0;
        for (int unsigned i = 0; i < NumCh; i++) begin
            w_cand = 32'(r_ptr) + i;
            if (w_cand >= NumCh) begin
                w_cand = w_cand - NumCh;
            end
            if (!w_found && i_req[IdxW'(w_cand)]) begin
                w_found                = 1'b1;
                o_gnt[IdxW'(w_cand)]   = 1'b1;
                o_gnt_idx              = IdxW'(w_cand);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ptr <= '0;
        end else if (|o_gnt) begin
            r_ptr <= (o_gnt_idx == IdxW'(NumCh - 1)) ? '0 : o_gnt_idx + IdxW'(1);
        end
    end
endmodule

// File: rtl/cheri_trvk_mc.sv
// Multi-channel revocation lookup: round-robin grant, bitmap word read, fixed three-cycle clear-tag verdict.
module cheri_trvk_mc
    import cheri_trvk_mc_pkg::*;
#(
    parameter logic [31:0] HeapBase  = 32'h8000_0000,
    parameter int unsigned TSMapSize = 1024,
    parameter int unsigned NumCh     = 2,
    parameter int unsigned GranLog2  = 3,
    parameter int unsigned TSMapDW   = 32,
    parameter int unsigned TSMapAW   = 16,
    parameter int unsigned TagW      = 5
) (
    input  logic           clk_i,
    input  logic           rst_i,
    cheri_trvk_mc_if.slave bus
);
    localparam int unsigned IdxW = (NumCh > 1) ? $clog2(NumCh) : 1;
    localparam int unsigned BitW = $clog2(TSMapDW);

    if (NumCh < 1 || NumCh > 8) begin : g_bad_numch
        $error("cheri_trvk_mc: NumCh must be 1..8");
    end
    if (TSMapDW < 8 || TSMapDW > 64 || (TSMapDW & (TSMapDW - 1)) != 0) begin : g_bad_dw
        $error("cheri_trvk_mc: TSMapDW must be a power of two in 8..64");
    end
    if (TagW < 1 || TagW > TrvkTagMaxW) begin : g_bad_tagw
        $error("cheri_trvk_mc: TagW out of range");
    end
    if (TSMapAW < 1 || TSMapAW > 32 || (TSMapAW < 32 && TSMapSize > (1 << TSMapAW))) begin : g_bad_aw
        $error("cheri_trvk_mc: map does not fit the word address width");
    end

    logic [NumCh-1:0] w_gnt;
    logic [IdxW-1:0]  w_gnt_idx;
    trvk_req_t        w_s0_in;

    logic             r_s0_valid;
    trvk_req_t        r_s0_req;
    logic [NumCh-1:0] r_s0_ch;

    logic [32:0]      w_bound;
    logic [31:0]      w_off;
    logic [31:0]      w_gran;
    logic [31:0]      w_widx;
    logic [BitW-1:0]  w_bit;
    logic             w_check;

    logic             r_s1_valid;
    logic             r_s1_check;
    logic [BitW-1:0]  r_s1_bit;
    logic [TagW-1:0]  r_s1_tag;
    logic [NumCh-1:0] r_s1_ch;

    logic [NumCh-1:0] r_rsp_valid;
    logic             r_rsp_clr;
    logic [TagW-1:0]  r_rsp_tag;

    cheri_trvk_rrarb #(.NumCh(NumCh), .IdxW(IdxW)) u_rrarb (
        .clk_i,
        .rst_i,
        .i_req     (bus.req_valid),
        .o_gnt     (w_gnt),
        .o_gnt_idx (w_gnt_idx)
    );

    assign bus.req_ready = rst_i ? '0 : w_gnt;

    always_comb begin
        w_s0_in      = NULL_TRVK_REQ;
        w_s0_in.cap  = bus.req_cap[w_gnt_idx];
        w_s0_in.data = bus.req_data[w_gnt_idx];
        w_s0_in.err  = bus.req_err[w_gnt_idx];
        w_s0_in.tag  = TrvkTagMaxW'(bus.req_tag[w_gnt_idx]);
    end

    // A base below the heap wraps to a huge word index and fails the range test.
    assign w_bound = get_bound33(r_s0_req.cap.base, r_s0_req.cap.base_cor, r_s0_req.cap.exp, r_s0_req.data);
    assign w_off   = w_bound[31:0] - HeapBase;
    assign w_gran  = w_off >> GranLog2;
    assign w_widx  = w_gran >> BitW;
    assign w_bit   = w_gran[BitW-1:0];
    assign w_check = r_s0_valid & ~r_s0_req.err & r_s0_req.cap.valid & ~cap_is_sealed(r_s0_req.cap)
                   & (w_widx < TSMapSize) & bus.revoke_en;

    assign bus.tsmap_cs   = w_check;
    assign bus.tsmap_addr = w_check ? w_widx[TSMapAW-1:0] : '0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_s0_valid  <= 1'b0;
            r_s0_req    <= NULL_TRVK_REQ;
            r_s0_ch     <= '0;
            r_s1_valid  <= 1'b0;
            r_s1_check  <= 1'b0;
            r_s1_bit    <= '0;
            r_s1_tag    <= '0;
            r_s1_ch     <= '0;
            r_rsp_valid <= '0;
            r_rsp_clr   <= 1'b0;
            r_rsp_tag   <= '0;
        end else begin
            r_s0_valid <= |w_gnt;
            r_s0_ch    <= w_gnt;
            if (|w_gnt) begin
                r_s0_req <= w_s0_in;
            end
            r_s1_valid  <= r_s0_valid;
            r_s1_check  <= w_check;
            r_s1_bit    <= w_bit;
            r_s1_tag    <= r_s0_req.tag[TagW-1:0];
            r_s1_ch     <= r_s0_ch;
            r_rsp_valid <= r_s1_valid ? r_s1_ch : '0;
            r_rsp_clr   <= r_s1_valid & r_s1_check & bus.tsmap_rdata[r_s1_bit];
            r_rsp_tag   <= r_s1_valid ? r_s1_tag : '0;
        end
    end

    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_clrtag = r_rsp_clr;
    assign bus.rsp_tag    = r_rsp_tag;

    logic w_unused;
    assign w_unused = ^{w_bound[32], r_s0_req.cap.top, r_s0_req.cap.top_cor, r_s0_req.cap.cperms[5], r_s0_req.tag};
endmodule

// File: tb/tb_cheri_trvk_mc.sv
// Randomised and directed bench for cheri_trvk_mc against a cycle-indexed reference of grants and verdicts.
module tb_cheri_trvk_mc;
    import cheri_trvk_mc_pkg::*;

    localparam int NCH   = 2;
    localparam int TW    = 5;
    localparam int DW    = 32;
    localparam int AW    = 16;
    localparam int MSIZE = 1024;
    localparam logic [31:0] HEAP = 32'h8000_0000;

    typedef struct {
        bit          v;
        int          ch;
        reg_cap_t    cap;
        bit [31:0]   data;
        bit          err;
        bit [TW-1:0] tag;
    } ent_t;

    logic clk = 1'b0;
    logic rst;
    logic [DW-1:0] mem [MSIZE];
    ent_t hist [8];
    bit   en_hist [8];
    int   cyc = 0;
    int   rr = 0;
    int   n_pass = 0;
    int   n_chk = 0;

    cheri_trvk_mc_if #(.NumCh(NCH), .TagW(TW), .TSMapDW(DW), .TSMapAW(AW)) bus ();

    cheri_trvk_mc #(
        .HeapBase(HEAP), .TSMapSize(MSIZE), .NumCh(NCH), .GranLog2(3),
        .TSMapDW(DW), .TSMapAW(AW), .TagW(TW)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.tsmap_cs) bus.tsmap_rdata <= mem[bus.tsmap_addr[9:0]];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Capability base by plain arithmetic: aligned address plus correction, plus the scaled mantissa.
    function automatic bit [31:0] m_off(ent_t e);
        longint sh, corv, b;
        sh   = longint'(e.cap.exp) + 9;
        corv = (e.cap.base_cor == 2'b01) ? 1 : (e.cap.base_cor == 2'b11) ? -1 : 0;
        b    = (((longint'(e.data) >> sh) + corv) << sh) + (longint'(e.cap.base) << e.cap.exp);
        return b[31:0] - HEAP;
    endfunction

    function automatic bit m_check(ent_t e, bit en);
        bit [31:0] off;
        bit sealed;
        off    = m_off(e);
        sealed = (e.cap.cperms[4:3] == 2'b00) && (e.cap.cperms[2:0] != 3'b000);
        return e.v && !e.err && e.cap.valid && !sealed && ((off / 256) < MSIZE) && en;
    endfunction

    function automatic bit m_clr(ent_t e, bit en);
        bit [31:0] off;
        logic [9:0] wi;
        logic [4:0] bi;
        logic [DW-1:0] w;
        off = m_off(e);
        wi  = 10'(off / 256);
        bi  = 5'((off / 8) % 32);
        w   = mem[wi];
        return m_check(e, en) && w[bi];
    endfunction

    task automatic step(output int g);
        ent_t e0, e1, e3;
        bit cs;
        logic [NCH-1:0] er;
        #1;
        g = -1;
        if (!rst) begin
            for (int i = 0; i < NCH; i++) begin
                int c;
                c = (rr + i) % NCH;
                if (g < 0 && bus.req_valid[c]) g = c;
            end
        end
        er = (g < 0) ? '0 : NCH'(1 << g);
        chk("req_ready", 64'(bus.req_ready), 64'(er));

        e1 = hist[(cyc + 7) % 8];
        cs = m_check(e1, bus.revoke_en);
        chk("tsmap_cs", 64'(bus.tsmap_cs), 64'(cs));
        if (cs) chk("tsmap_addr", 64'(bus.tsmap_addr), 64'(m_off(e1) / 256));
        if (rst) chk("tsmap_addr_rst", 64'(bus.tsmap_addr), 64'd0);

        e3 = hist[(cyc + 5) % 8];
        if (e3.v) begin
            chk("rsp_valid", 64'(bus.rsp_valid), 64'(1 << e3.ch));
            chk("rsp_clrtag", 64'(bus.rsp_clrtag), 64'(m_clr(e3, en_hist[(cyc + 6) % 8])));
            chk("rsp_tag", 64'(bus.rsp_tag), 64'(e3.tag));
        end else begin
            chk("rsp_valid_idle", 64'(bus.rsp_valid), 64'd0);
            chk("rsp_clrtag_idle", 64'(bus.rsp_clrtag), 64'd0);
            chk("rsp_tag_idle", 64'(bus.rsp_tag), 64'd0);
        end

        e0.v = (g >= 0);
        e0.ch = (g >= 0) ? g : 0;
        e0.cap = (g >= 0) ? bus.req_cap[g] : '0;
        e0.data = (g >= 0) ? bus.req_data[g] : '0;
        e0.err = (g >= 0) ? bus.req_err[g] : 1'b0;
        e0.tag = (g >= 0) ? bus.req_tag[g] : '0;
        hist[cyc % 8] = e0;
        en_hist[cyc % 8] = bus.revoke_en;
        if (g >= 0) rr = (g + 1) % NCH;
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        int g;
        rst = 1'b1;
        for (int i = 0; i < 8; i++) hist[i].v = 1'b0;
        rr = 0;
        repeat (n) step(g);
        rst = 1'b0;
    endtask

    task automatic idle(input int n);
        int g;
        bus.req_valid = '0;
        repeat (n) step(g);
    endtask

    // Directed requests use exp 0 and no correction, so the capability base equals the address word.
    task automatic put(input int c, input bit [31:0] d, input bit [5:0] perms, input bit err, input bit [TW-1:0] tag);
        reg_cap_t cp;
        cp = '0;
        cp.valid = 1'b1;
        cp.base = d[8:0];
        cp.top = 9'h1FF;
        cp.cperms = perms;
        bus.req_valid[c] = 1'b1;
        bus.req_cap[c] = cp;
        bus.req_data[c] = d;
        bus.req_err[c] = err;
        bus.req_tag[c] = tag;
    endtask

    task automatic send(input int c, input bit [31:0] d, input bit [5:0] perms, input bit err, input bit [TW-1:0] tag);
        int g;
        put(c, d, perms, err, tag);
        step(g);
        bus.req_valid[c] = 1'b0;
    endtask

    task automatic set_rand(input int c);
        reg_cap_t cp;
        int r;
        cp = '0;
        cp.valid = ($urandom_range(0, 9) != 0);
        cp.exp = 5'($urandom_range(0, 4));
        cp.base = 9'($urandom);
        cp.top = 9'($urandom);
        r = $urandom_range(0, 2);
        cp.base_cor = (r == 2) ? 2'b11 : 2'(r);
        cp.cperms = 6'($urandom);
        bus.req_valid[c] = 1'b1;
        bus.req_cap[c] = cp;
        bus.req_data[c] = 32'h7FFF_F000 + $urandom_range(0, 32'h0004_2000);
        bus.req_err[c] = ($urandom_range(0, 9) == 0);
        bus.req_tag[c] = TW'($urandom);
    endtask

    initial begin
        int g;
        rst = 1'b1;
        bus.revoke_en = 1'b1;
        bus.req_valid = '0;
        bus.req_cap = '0;
        bus.req_data = '0;
        bus.req_err = '0;
        bus.req_tag = '0;
        for (int i = 0; i < MSIZE; i++) mem[i] = '0;
        for (int i = 0; i < 8; i++) begin
            hist[i].v = 1'b0;
            en_hist[i] = 1'b0;
        end
        mem[1] = 32'h0000_0002;
        mem[1023] = 32'h8000_0000;
        @(negedge clk);
        do_reset(3);
        idle(2);

        // single hit, then miss, sealed, errored and globally disabled
        send(0, 32'h8000_0108, 6'h3F, 1'b0, 5'h07);
        idle(4);
        mem[1] = '0;
        send(0, 32'h8000_0108, 6'h3F, 1'b0, 5'h08);
        idle(4);
        mem[1] = 32'h0000_0002;
        send(0, 32'h8000_0108, 6'h01, 1'b0, 5'h09);
        send(0, 32'h8000_0108, 6'h3F, 1'b1, 5'h0A);
        idle(4);
        bus.revoke_en = 1'b0;
        send(1, 32'h8000_0108, 6'h3F, 1'b0, 5'h0B);
        idle(1);
        bus.revoke_en = 1'b1;
        idle(3);

        // range edges: below heap, one word past the map, last word
        send(1, 32'h7FFF_FFF8, 6'h3F, 1'b0, 5'h10);
        send(1, 32'h8004_0000, 6'h3F, 1'b0, 5'h11);
        send(1, 32'h8003_FFFC, 6'h3F, 1'b0, 5'h12);
        idle(4);

        // both channels requesting: grants alternate
        put(0, 32'h8000_0108, 6'h3F, 1'b0, 5'h00);
        put(1, 32'h8000_0100, 6'h3F, 1'b0, 5'h10);
        for (int k = 0; k < 4; k++) begin
            step(g);
            if (g >= 0) bus.req_tag[g] = bus.req_tag[g] + 5'd1;
        end
        idle(4);

        // back-to-back on one channel with alternating map bits
        mem[2] = 32'h0000_0005;
        for (int k = 0; k < 3; k++) begin
            put(1, 32'h8000_0200 + 32'(k * 8), 6'h3F, 1'b0, 5'(20 + k));
            step(g);
        end
        idle(4);

        // reset while a request is in flight; pointer must return to channel 0
        send(0, 32'h8000_0108, 6'h3F, 1'b0, 5'h1E);
        step(g);
        do_reset(2);
        put(0, 32'h8000_0108, 6'h3F, 1'b0, 5'h01);
        put(1, 32'h8000_0108, 6'h3F, 1'b0, 5'h02);
        step(g);
        idle(5);

        for (int i = 0; i < MSIZE; i++) mem[i] = DW'($urandom);
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 15) == 0) bus.revoke_en = ~bus.revoke_en;
            for (int c = 0; c < NCH; c++) begin
                if (bus.req_valid[c]) begin
                    if ($urandom_range(0, 7) == 0) bus.req_valid[c] = 1'b0;
                end else if ($urandom_range(0, 2) != 0) begin
                    set_rand(c);
                end
            end
            step(g);
            if (g >= 0) begin
                bus.req_valid[g] = 1'b0;
                if ($urandom_range(0, 3) != 0) set_rand(g);
            end
        end
        bus.revoke_en = 1'b1;
        idle(5);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
